// File: rtl/mdom_trig_gen.sv
// Per-channel trigger generator: threshold, discriminator and external
// trigger sources feed an IDLE/ARMED/HOLDOFF FSM that emits single-cycle
// trigger pulses with a source code and a wrapping trigger count.
module mdom_trig_gen #(
   parameter int HOLDOFF = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig_et,
   input  logic             trig_gt,
   input  logic             trig_lt,
   input  logic             trig_run,
   input  logic             discr_trig_pol,
   input  logic [11:0]      trig_thresh,
   input  logic             disc_trig_en,
   input  logic             thresh_trig_en,
   input  logic             ext_trig_en,
   input  logic [11:0]      adc_data,
   input  logic             adc_valid,
   input  logic             discr_in,
   input  logic             ext_trig_in,
   output logic             trig,
   output logic [2:0]       trig_src,
   output logic [CNT_W-1:0] trig_cnt,
   output logic             armed
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [11:0]        s1_data_q, s1_data_d;
   logic               s1_valid_q, s1_valid_d;
   logic [11:0]        prev_q, prev_d;
   logic               thr_hit_q, thr_hit_d;
   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               disc_lvl_q, disc_lvl_d;
   logic               disc_hit_q, disc_hit_d;
   logic               ext_hit_q, ext_hit_d;
   logic [15:0]        hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
   logic               cur_lvl;
   logic               et, gt, lt;
   logic [2:0]         hit_vec;

   // Source pipelines: sample stage, threshold compare, discriminator sync/edge, external.
   always_comb begin
      s1_data_d  = adc_data;
      s1_valid_d = adc_valid;

      et = (prev_q < trig_thresh) && (s1_data_q >= trig_thresh);
      gt = s1_data_q > trig_thresh;
      lt = s1_data_q < trig_thresh;
      thr_hit_d = thresh_trig_en & s1_valid_q &
                  ((trig_et & et) | (trig_gt & gt) | (trig_lt & lt));

      // prev is held at zero while disarmed so the first sample after arming
      // can produce an edge crossing.
      prev_d = prev_q;
      if (state_q == ST_IDLE) begin
         prev_d = '0;
      end else if (s1_valid_q) begin
         prev_d = s1_data_q;
      end

      sync1_d    = discr_in;
      sync2_d    = sync1_q;
      cur_lvl    = sync2_q ^ discr_trig_pol;
      disc_lvl_d = cur_lvl;
      disc_hit_d = disc_trig_en & cur_lvl & ~disc_lvl_q;

      ext_hit_d = ext_trig_en & ext_trig_in;
   end

   // Trigger FSM: next state, holdoff counter, trigger count and pulse outputs.
   always_comb begin
      hit_vec    = {ext_hit_q, disc_hit_q, thr_hit_q};
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      trig_cnt_d = trig_cnt_q;
      trig       = 1'b0;
      trig_src   = 3'b000;
      case (state_q)
         ST_IDLE: begin
            hold_cnt_d = '0;
            if (trig_run) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!trig_run) begin
               state_d = ST_IDLE;
            end else if (|hit_vec) begin
               trig       = 1'b1;
               trig_src   = hit_vec;
               trig_cnt_d = trig_cnt_q + CNT_W'(1);
               hold_cnt_d = 16'(HOLDOFF - 1);
               state_d    = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (!trig_run) begin
               state_d    = ST_IDLE;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == '0) begin
               state_d = ST_ARMED;
            end else begin
               hold_cnt_d = hold_cnt_q - 16'd1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   // State and pipeline registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
         prev_q     <= '0;
         thr_hit_q  <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         disc_lvl_q <= 1'b0;
         disc_hit_q <= 1'b0;
         ext_hit_q  <= 1'b0;
         hold_cnt_q <= '0;
         trig_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         s1_data_q  <= s1_data_d;
         s1_valid_q <= s1_valid_d;
         prev_q     <= prev_d;
         thr_hit_q  <= thr_hit_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         disc_lvl_q <= disc_lvl_d;
         disc_hit_q <= disc_hit_d;
         ext_hit_q  <= ext_hit_d;
         hold_cnt_q <= hold_cnt_d;
         trig_cnt_q <= trig_cnt_d;
      end
   end

   assign trig_cnt = trig_cnt_q;
   assign armed    = (state_q == ST_ARMED);

endmodule
